mem_arbiter: RTL and testbench

Shares the single physical memory port between the pipeline's instruction-fetch requester and its data-access requester. It sits between the CPU's address-translation logic and the physical memory controller. It serialises requests into one outstanding device access at a time. Data accesses get priority, and a bounded anti-starvation counter guarantees instruction fetches still progress.

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one physical memory port between an instruction-fetch requester
// and a data requester; one device access in flight, data favoured, bounded fairness.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_ack,
  input  logic        data_req,
  input  logic        data_is_write,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        arb_busy,
  output logic        dev_mem_req,
  output logic [31:0] dev_mem_addr,
  output logic        dev_mem_is_write,
  output logic [31:0] dev_mem_data_out,
  input  logic [31:0] dev_mem_data_in,
  input  logic        dev_mem_busy,
  output logic [1:0]  dbg_state_o,
  output logic [3:0]  dbg_starve_cnt_o
);

  // Handshake: a requester raises req and holds it (with stable attributes)
  // until its one-cycle ack; inputs are only sampled in IDLE, and a req still
  // high in IDLE after the ack is treated as a fresh request.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic        owner_q, owner_d;          // 1 = data port owns the access
  logic [31:0] addr_q, addr_d;
  logic        is_write_q, is_write_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] instr_rdata_q, instr_rdata_d;
  logic [31:0] data_rdata_q, data_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      starve_q      <= 4'd0;
      owner_q       <= 1'b0;
      addr_q        <= 32'd0;
      is_write_q    <= 1'b0;
      wdata_q       <= 32'd0;
      instr_rdata_q <= 32'd0;
      data_rdata_q  <= 32'd0;
    end else begin
      state_q       <= state_d;
      starve_q      <= starve_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      is_write_q    <= is_write_d;
      wdata_q       <= wdata_d;
      instr_rdata_q <= instr_rdata_d;
      data_rdata_q  <= data_rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    is_write_d    = is_write_q;
    wdata_d       = wdata_q;
    instr_rdata_d = instr_rdata_q;
    data_rdata_d  = data_rdata_q;
    case (state_q)
      IDLE: begin
        // Data wins unless the waiting fetch has already been passed LIMIT times.
        if (data_req && (!instr_req || (starve_q < LIMIT))) begin
          state_d    = ACCESS;
          owner_d    = 1'b1;
          addr_d     = data_addr;
          is_write_d = data_is_write;
          wdata_d    = data_is_write ? data_wdata : 32'd0;
          if (instr_req) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
          end else begin
            starve_d = 4'd0;
          end
        end else if (instr_req) begin
          state_d    = ACCESS;
          owner_d    = 1'b0;
          addr_d     = instr_addr;
          is_write_d = 1'b0;
          wdata_d    = 32'd0;
          starve_d   = 4'd0;
        end
      end
      ACCESS: begin
        if (!dev_mem_busy) begin
          state_d = DONE;
          if (!is_write_q) begin
            if (owner_q) begin
              data_rdata_d = dev_mem_data_in;
            end else begin
              instr_rdata_d = dev_mem_data_in;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode straight from registers so reset removes them immediately.
  assign arb_busy         = (state_q != IDLE);
  assign dev_mem_req      = (state_q == ACCESS);
  assign instr_ack        = (state_q == DONE) && !owner_q;
  assign data_ack         = (state_q == DONE) && owner_q;
  assign dev_mem_addr     = addr_q;
  assign dev_mem_is_write = is_write_q;
  assign dev_mem_data_out = wdata_q;
  assign instr_rdata      = instr_rdata_q;
  assign data_rdata       = data_rdata_q;
  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: hand-computed per-cycle expectations
// for reads, slow writes, starvation ordering, mid-access reset and held requests.
module tb_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = 32'd0;
  logic [31:0] instr_rdata;
  logic        instr_ack;
  logic        data_req = 1'b0;
  logic        data_is_write = 1'b0;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wdata = 32'd0;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        arb_busy;
  logic        dev_mem_req;
  logic [31:0] dev_mem_addr;
  logic        dev_mem_is_write;
  logic [31:0] dev_mem_data_out;
  logic [31:0] dev_mem_data_in = 32'd0;
  logic        dev_mem_busy = 1'b0;
  logic [1:0]  dbg_state;
  logic [3:0]  dbg_starve_cnt;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .instr_req        (instr_req),
    .instr_addr       (instr_addr),
    .instr_rdata      (instr_rdata),
    .instr_ack        (instr_ack),
    .data_req         (data_req),
    .data_is_write    (data_is_write),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_rdata       (data_rdata),
    .data_ack         (data_ack),
    .arb_busy         (arb_busy),
    .dev_mem_req      (dev_mem_req),
    .dev_mem_addr     (dev_mem_addr),
    .dev_mem_is_write (dev_mem_is_write),
    .dev_mem_data_out (dev_mem_data_out),
    .dev_mem_data_in  (dev_mem_data_in),
    .dev_mem_busy     (dev_mem_busy),
    .dbg_state_o      (dbg_state),
    .dbg_starve_cnt_o (dbg_starve_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the next falling edge and check the always-true exclusivity rules.
  task automatic step();
    @(negedge clk);
    check("ack_excl", {31'd0, instr_ack & data_ack}, 32'd0);
    check("req_ack_excl", {31'd0, dev_mem_req & (instr_ack | data_ack)}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] exp_addr;
    logic [6:0]  exp_req_v;
    logic [6:0]  exp_ack_v;
    int          ack_count;

    // ---------- reset state ----------
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, 32'd0);
    check("rst_busy", arb_busy, 32'd0);
    check("rst_req", dev_mem_req, 32'd0);
    check("rst_iack", instr_ack, 32'd0);
    check("rst_dack", data_ack, 32'd0);
    check("rst_addr", dev_mem_addr, 32'd0);
    check("rst_wdata", dev_mem_data_out, 32'd0);
    check("rst_we", dev_mem_is_write, 32'd0);
    check("rst_irdata", instr_rdata, 32'd0);
    check("rst_drdata", data_rdata, 32'd0);
    check("rst_starve", dbg_starve_cnt, 32'd0);
    rst = 1'b0;
    step();

    // ---------- instruction read, fast device ----------
    instr_req = 1'b1;
    instr_addr = 32'h0000_0100;
    dev_mem_busy = 1'b0;
    dev_mem_data_in = 32'hDEAD_BEEF;
    check("ird_c0_req", dev_mem_req, 32'd0);
    step();
    check("ird_c1_req", dev_mem_req, 32'd1);
    check("ird_c1_we", dev_mem_is_write, 32'd0);
    check("ird_c1_addr", dev_mem_addr, 32'h0000_0100);
    check("ird_c1_iack", instr_ack, 32'd0);
    step();
    check("ird_c2_iack", instr_ack, 32'd1);
    check("ird_c2_req", dev_mem_req, 32'd0);
    check("ird_c2_rdata", instr_rdata, 32'hDEAD_BEEF);
    instr_req = 1'b0;
    step();
    check("ird_c3_iack", instr_ack, 32'd0);
    check("ird_c3_state", dbg_state, 32'd0);

    // ---------- data write, slow device, input isolation ----------
    data_req = 1'b1;
    data_is_write = 1'b1;
    data_addr = 32'h8000_0004;
    data_wdata = 32'h1234_5678;
    dev_mem_busy = 1'b1;
    dev_mem_data_in = 32'hCAFE_F00D;
    step();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) begin
        data_addr = 32'h1111_0000;
        data_wdata = 32'h0;
      end
      if (c == 4) dev_mem_busy = 1'b0;
      check("wr_req", dev_mem_req, 32'd1);
      check("wr_addr", dev_mem_addr, 32'h8000_0004);
      check("wr_data", dev_mem_data_out, 32'h1234_5678);
      check("wr_we", dev_mem_is_write, 32'd1);
      check("wr_dack", data_ack, 32'd0);
      step();
    end
    check("wr_c5_dack", data_ack, 32'd1);
    check("wr_c5_req", dev_mem_req, 32'd0);
    check("wr_c5_rdata", data_rdata, 32'd0);
    data_req = 1'b0;
    data_is_write = 1'b0;
    step();
    check("wr_c6_busy", arb_busy, 32'd0);

    // ---------- starvation: D,D,D,D,I ----------
    instr_req = 1'b1;
    instr_addr = 32'h0000_0200;
    data_req = 1'b1;
    data_addr = 32'h0000_0300;
    repeat (4) exp_q.push_back(32'h0000_0300);
    exp_q.push_back(32'h0000_0200);
    for (int i = 0; i < 5; i++) begin
      check("stv_pre_cnt", dbg_starve_cnt, i);
      dev_mem_data_in = 32'hA000_0000 + i;
      step();
      exp_addr = exp_q.pop_front();
      check("stv_grant_addr", dev_mem_addr, exp_addr);
      if (i == 4) check("stv_post_cnt", dbg_starve_cnt, 32'd0);
      step();
      check("stv_dack", data_ack, (exp_addr == 32'h0000_0300));
      check("stv_iack", instr_ack, (exp_addr == 32'h0000_0200));
      if (exp_addr == 32'h0000_0300) check("stv_drdata", data_rdata, 32'hA000_0000 + i);
      else check("stv_irdata", instr_rdata, 32'hA000_0000 + i);
      if (i == 4) begin
        instr_req = 1'b0;
        data_req = 1'b0;
      end
      step();
    end

    // ---------- reset in the 2nd ACCESS cycle of a data read ----------
    data_req = 1'b1;
    data_is_write = 1'b0;
    data_addr = 32'h0000_0040;
    dev_mem_busy = 1'b1;
    step();
    check("rma_c1_req", dev_mem_req, 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("rma_req", dev_mem_req, 32'd0);
    check("rma_dack", data_ack, 32'd0);
    check("rma_state", dbg_state, 32'd0);
    check("rma_drdata", data_rdata, 32'd0);
    check("rma_irdata", instr_rdata, 32'd0);
    data_req = 1'b0;
    dev_mem_busy = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    check("rma_after_dack", data_ack, 32'd0);
    check("rma_after_state", dbg_state, 32'd0);

    // ---------- held instruction request: accesses in cycles 1 and 4 ----------
    exp_req_v = 7'b0010010;
    exp_ack_v = 7'b0100100;
    ack_count = 0;
    instr_req = 1'b1;
    instr_addr = 32'h0000_0500;
    dev_mem_data_in = 32'h5555_AAAA;
    for (int c = 0; c < 7; c++) begin
      check("held_req", dev_mem_req, exp_req_v[c]);
      check("held_iack", instr_ack, exp_ack_v[c]);
      if (instr_ack) ack_count++;
      if (c == 5) instr_req = 1'b0;
      step();
    end
    check("held_ack_count", ack_count, 32'd2);
    check("held_irdata", instr_rdata, 32'h5555_AAAA);

    // ---------- final report ----------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
